// File: rtl/lsu_mem_port.sv
// lsu_mem_port: initiator side of the core's data-memory port.
// Takes one load/store from execute, drives a 64-bit, 8-byte aligned word
// interface with byte strobes and 1-cycle read latency, splits accesses that
// cross an 8-byte boundary into two beats and merges/extends load data.
//
// Ports:
//   i_Clock, i_Reset      rising-edge clock, synchronous active-low reset
//   i_Valid / o_Ready     request handshake (accept on i_Valid & o_Ready)
//   i_MemWrite, i_Funct3  store/load select and RISC-V size/sign code
//   i_Address, i_Data     byte address (any alignment), right-justified store data
//   o_Done, o_Data        completion pulse and load result
//   o_Error               pulses with o_Done for an illegal funct3
//   o_MemReq, o_MemWrite, o_MemAddr, o_MemWData, o_MemWStrb   memory beat
//   i_MemRData            read data, valid the cycle after a read beat
module lsu_mem_port #(
    parameter int unsigned XLEN = 64
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Valid,
    output logic              o_Ready,
    input  logic              i_MemWrite,
    input  logic [2:0]        i_Funct3,
    input  logic [XLEN-1:0]   i_Address,
    input  logic [XLEN-1:0]   i_Data,
    output logic              o_Done,
    output logic [XLEN-1:0]   o_Data,
    output logic              o_Error,
    output logic              o_MemReq,
    output logic              o_MemWrite,
    output logic [XLEN-1:0]   o_MemAddr,
    output logic [XLEN-1:0]   o_MemWData,
    output logic [XLEN/8-1:0] o_MemWStrb,
    input  logic [XLEN-1:0]   i_MemRData
);

    localparam int unsigned STRB_W = XLEN / 8;
    localparam int unsigned SPAN_W = 2 * XLEN;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_REQ1,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            r_State, n_State;
    logic              r_IsStore;
    logic [2:0]        r_Funct3;
    logic [XLEN-1:0]   r_Addr;
    logic [XLEN-1:0]   r_Data;
    logic [XLEN-1:0]   r_Beat0;

    logic              w_Idle, w_Accept, w_IsStore, w_Illegal, w_Split;
    logic [2:0]        w_Funct3, w_Offset;
    logic [3:0]        w_Size;
    logic [XLEN-1:0]   w_Addr, w_Data, w_BeatAddr0;
    logic [STRB_W-1:0] w_SizeMask;
    logic [XLEN-1:0]   w_DataMask;
    logic [SPAN_W-1:0] w_StoreSpan;
    logic [2*STRB_W-1:0] w_StrbSpan;
    logic [XLEN-1:0]   w_LoadLo, w_LoadHi, w_LoadRaw, w_LoadResult;

    logic              n_Ready, n_Done, n_Error, n_MemReq, n_MemWrite;
    logic [XLEN-1:0]   n_Data, n_MemAddr, n_MemWData;
    logic [STRB_W-1:0] n_MemWStrb;

    // Request view: live inputs while idle (accept edge), latched copy otherwise
    always_comb begin
        w_Idle    = (r_State == S_IDLE);
        w_Accept  = w_Idle & i_Valid;
        w_IsStore = w_Idle ? i_MemWrite : r_IsStore;
        w_Funct3  = w_Idle ? i_Funct3   : r_Funct3;
        w_Addr    = w_Idle ? i_Address  : r_Addr;
        w_Data    = w_Idle ? i_Data     : r_Data;
        w_Illegal = w_IsStore ? w_Funct3[2] : (w_Funct3 == 3'b111);
        w_Offset  = w_Addr[2:0];
        w_BeatAddr0 = {w_Addr[XLEN-1:3], 3'b000};
    end

    // Access size, lane masks and boundary-crossing detection
    always_comb begin
        w_Size     = 4'd1;
        w_SizeMask = 8'h01;
        case (w_Funct3[1:0])
            2'b00: begin w_Size = 4'd1; w_SizeMask = 8'h01; end
            2'b01: begin w_Size = 4'd2; w_SizeMask = 8'h03; end
            2'b10: begin w_Size = 4'd4; w_SizeMask = 8'h0F; end
            default: begin w_Size = 4'd8; w_SizeMask = 8'hFF; end
        endcase
        w_Split = (4'(w_Offset) + w_Size) > 4'd8;
        w_DataMask = '0;
        for (int i = 0; i < STRB_W; i++) begin
            w_DataMask[8*i +: 8] = {8{w_SizeMask[i]}};
        end
    end

    // Store lane alignment across the two-beat span
    always_comb begin
        w_StoreSpan = {{XLEN{1'b0}}, w_Data & w_DataMask} << {w_Offset, 3'b000};
        w_StrbSpan  = {{STRB_W{1'b0}}, w_SizeMask} << w_Offset;
    end

    // Load merge: beat0 was captured in REQ1 for split loads, live data is the last beat
    always_comb begin
        w_LoadLo  = w_Split ? r_Beat0 : i_MemRData;
        w_LoadHi  = w_Split ? i_MemRData : {XLEN{1'b0}};
        w_LoadRaw = XLEN'({w_LoadHi, w_LoadLo} >> {w_Offset, 3'b000});
        case (r_Funct3)
            3'b000:  w_LoadResult = {{(XLEN-8){w_LoadRaw[7]}},   w_LoadRaw[7:0]};
            3'b001:  w_LoadResult = {{(XLEN-16){w_LoadRaw[15]}}, w_LoadRaw[15:0]};
            3'b010:  w_LoadResult = {{(XLEN-32){w_LoadRaw[31]}}, w_LoadRaw[31:0]};
            3'b011:  w_LoadResult = w_LoadRaw;
            3'b100:  w_LoadResult = {{(XLEN-8){1'b0}},  w_LoadRaw[7:0]};
            3'b101:  w_LoadResult = {{(XLEN-16){1'b0}}, w_LoadRaw[15:0]};
            3'b110:  w_LoadResult = {{(XLEN-32){1'b0}}, w_LoadRaw[31:0]};
            default: w_LoadResult = {XLEN{1'b0}};
        endcase
    end

    // Next state and next registered outputs
    always_comb begin
        n_State    = r_State;
        n_Ready    = 1'b0;
        n_Done     = 1'b0;
        n_Error    = 1'b0;
        n_MemReq   = 1'b0;
        n_MemWrite = 1'b0;
        n_MemAddr  = {XLEN{1'b0}};
        n_MemWData = {XLEN{1'b0}};
        n_MemWStrb = {STRB_W{1'b0}};
        n_Data     = o_Data;

        case (r_State)
            S_IDLE: if (i_Valid) n_State = w_Illegal ? S_DONE : S_REQ0;
            S_REQ0: begin
                if (w_Split)        n_State = S_REQ1;
                else if (w_IsStore) n_State = S_DONE;
                else                n_State = S_WAIT;
            end
            S_REQ1:  n_State = w_IsStore ? S_DONE : S_WAIT;
            S_WAIT:  n_State = S_DONE;
            S_DONE:  n_State = S_IDLE;
            default: n_State = S_IDLE;
        endcase

        n_Ready = (n_State == S_IDLE);
        n_Done  = (n_State == S_DONE);
        n_Error = w_Accept & w_Illegal;

        case (n_State)
            S_REQ0: begin
                n_MemReq  = 1'b1;
                n_MemAddr = w_BeatAddr0;
                if (w_IsStore) begin
                    n_MemWrite = 1'b1;
                    n_MemWData = w_StoreSpan[XLEN-1:0];
                    n_MemWStrb = w_StrbSpan[STRB_W-1:0];
                end
            end
            S_REQ1: begin
                n_MemReq  = 1'b1;
                n_MemAddr = w_BeatAddr0 + XLEN'(8);
                if (w_IsStore) begin
                    n_MemWrite = 1'b1;
                    n_MemWData = w_StoreSpan[SPAN_W-1:XLEN];
                    n_MemWStrb = w_StrbSpan[2*STRB_W-1:STRB_W];
                end
            end
            default: ;
        endcase

        if (n_Error)               n_Data = {XLEN{1'b0}};
        else if (r_State == S_WAIT) n_Data = w_LoadResult;
    end

    // State, request latch and output registers
    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            r_State    <= S_IDLE;
            r_IsStore  <= 1'b0;
            r_Funct3   <= 3'b000;
            r_Addr     <= {XLEN{1'b0}};
            r_Data     <= {XLEN{1'b0}};
            r_Beat0    <= {XLEN{1'b0}};
            o_Ready    <= 1'b1;
            o_Done     <= 1'b0;
            o_Error    <= 1'b0;
            o_Data     <= {XLEN{1'b0}};
            o_MemReq   <= 1'b0;
            o_MemWrite <= 1'b0;
            o_MemAddr  <= {XLEN{1'b0}};
            o_MemWData <= {XLEN{1'b0}};
            o_MemWStrb <= {STRB_W{1'b0}};
        end else begin
            r_State <= n_State;
            if (w_Accept) begin
                r_IsStore <= i_MemWrite;
                r_Funct3  <= i_Funct3;
                r_Addr    <= i_Address;
                r_Data    <= i_Data;
            end
            // First beat's read data arrives while the second beat is issued
            if ((r_State == S_REQ1) && !r_IsStore) r_Beat0 <= i_MemRData;
            o_Ready    <= n_Ready;
            o_Done     <= n_Done;
            o_Error    <= n_Error;
            o_Data     <= n_Data;
            o_MemReq   <= n_MemReq;
            o_MemWrite <= n_MemWrite;
            o_MemAddr  <= n_MemAddr;
            o_MemWData <= n_MemWData;
            o_MemWStrb <= n_MemWStrb;
        end
    end

endmodule
